rv32i_alu: RTL and testbench

- Integer execute-stage ALU for an RV32I pipeline. Performs all ten RV32I register/immediate arithmetic, logic, compare and shift operations.
- Operand A is either the EXE-stage PC or Xreg rs1. Operand B is the pre-selected second source (register or immediate).
- The result is combinational, available in the same cycle for the EXE/MEM pipeline register and bypass network. A registered copy is also provided.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/rv32i_alu_if.sv | 22 ++
 rtl/rv32i_shifter.sv | 22 ++
 rtl/rv32i_alu.sv | 78 +++++++
 tb/tb_rv32i_alu.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared RV32I ALU definitions: datapath width, sub-opcode encoding and a bit-reverse helper.
package alu_pkg;

  localparam int XLEN = 32;

  // Sub-opcode is {funct7[5], funct3}; decode and verification models reuse these.
  typedef enum logic [3:0] {
    ALU_OPC_ADD  = 4'h0,
    ALU_OPC_SLL  = 4'h1,
    ALU_OPC_SLT  = 4'h2,
    ALU_OPC_SLTU = 4'h3,
    ALU_OPC_XOR  = 4'h4,
    ALU_OPC_SRL  = 4'h5,
    ALU_OPC_OR   = 4'h6,
    ALU_OPC_AND  = 4'h7,
    ALU_OPC_SUB  = 4'h8,
    ALU_OPC_SRA  = 4'hD
  } alu_opc_e;

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32i_alu_if.sv
// EXE-stage operand bundle into the ALU and the combinational/registered results back out.
interface rv32i_alu_if;
  import alu_pkg::*;

  logic [3:0]      exe_alu_opc_r;
  logic            exe_sel_pc_r;
  logic [XLEN-1:0] exe_pc_r;
  logic [XLEN-1:0] exe_reg1_r;
  logic [XLEN-1:0] exe_src2_r;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] alu_result_r;

  modport master (
    output exe_alu_opc_r, exe_sel_pc_r, exe_pc_r, exe_reg1_r, exe_src2_r,
    input  alu_result, alu_result_r
  );

  modport slave (
    input  exe_alu_opc_r, exe_sel_pc_r, exe_pc_r, exe_reg1_r, exe_src2_r,
    output alu_result, alu_result_r
  );
endinterface

// File: rtl/rv32i_shifter.sv
// Single logarithmic right barrel shifter; the caller chooses the fill bit (0 or sign).
module rv32i_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      shamt,
  input  logic            fill,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] stage [0:5];

  assign stage[0] = data;

  // Stage i shifts by 2**i when shamt[i] is set, back-filling with the fill bit.
  for (genvar i = 0; i < 5; i++) begin : g_stage
    assign stage[i+1] = shamt[i] ? {{(2**i){fill}}, stage[i][XLEN-1:2**i]} : stage[i];
  end

  assign result = stage[5];

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU: combinational result for bypass plus a registered copy.
module rv32i_alu
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  rv32i_alu_if.slave   bus
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            do_sub;
  logic [XLEN-1:0] add_b;
  logic            carry;
  logic [XLEN-1:0] sum;
  logic            slt_bit;
  logic            sltu_bit;
  logic            is_sll;
  logic            shift_fill;
  logic [XLEN-1:0] shift_in;
  logic [XLEN-1:0] shift_out;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] result_q;

  assign op_a = bus.exe_sel_pc_r ? bus.exe_pc_r : bus.exe_reg1_r;
  assign op_b = bus.exe_src2_r;

  // Compares reuse the subtractor: SLTU is "no carry out of A + ~B + 1".
  assign do_sub = (bus.exe_alu_opc_r == ALU_OPC_SUB)  ||
                  (bus.exe_alu_opc_r == ALU_OPC_SLT)  ||
                  (bus.exe_alu_opc_r == ALU_OPC_SLTU);
  assign add_b  = do_sub ? ~op_b : op_b;
  assign {carry, sum} = {1'b0, op_a} + {1'b0, add_b} + {{XLEN{1'b0}}, do_sub};

  assign sltu_bit = ~carry;
  assign slt_bit  = (op_a[XLEN-1] != op_b[XLEN-1]) ? op_a[XLEN-1] : sum[XLEN-1];

  // Left shifts ride the right shifter by reversing bit order on both sides.
  assign is_sll     = (bus.exe_alu_opc_r == ALU_OPC_SLL);
  assign shift_fill = (bus.exe_alu_opc_r == ALU_OPC_SRA) ? op_a[XLEN-1] : 1'b0;
  assign shift_in   = is_sll ? bit_reverse(op_a) : op_a;

  rv32i_shifter u_shifter (
    .data   (shift_in),
    .shamt  (op_b[4:0]),
    .fill   (shift_fill),
    .result (shift_out)
  );

  always_comb begin
    result = '0;
    case (bus.exe_alu_opc_r)
      ALU_OPC_ADD,
      ALU_OPC_SUB:  result = sum;
      ALU_OPC_SLL:  result = bit_reverse(shift_out);
      ALU_OPC_SLT:  result = {{(XLEN-1){1'b0}}, slt_bit};
      ALU_OPC_SLTU: result = {{(XLEN-1){1'b0}}, sltu_bit};
      ALU_OPC_XOR:  result = op_a ^ op_b;
      ALU_OPC_SRL,
      ALU_OPC_SRA:  result = shift_out;
      ALU_OPC_OR:   result = op_a | op_b;
      ALU_OPC_AND:  result = op_a & op_b;
      default:      result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result;
    end
  end

  assign bus.alu_result   = result;
  assign bus.alu_result_r = result_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed vector table, reset sequences and random regression.
module tb_rv32i_alu;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  opc;
    logic        sel_pc;
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] src2;
    logic [31:0] expect_val;
    string       name;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];
  vec_t vecs[$];

  rv32i_alu_if bus();

  rv32i_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference written directly from the instruction semantics.
  function automatic logic [31:0] model(input logic [3:0] opc, input logic [31:0] a,
                                        input logic [31:0] b);
    case (opc)
      4'h0:    return a + b;
      4'h8:    return a - b;
      4'h1:    return a << b[4:0];
      4'h2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3:    return (a < b) ? 32'd1 : 32'd0;
      4'h4:    return a ^ b;
      4'h5:    return a >> b[4:0];
      4'h6:    return a | b;
      4'h7:    return a & b;
      4'hD:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic vec_t mk(input string name, input logic [3:0] opc, input logic sel_pc,
                              input logic [31:0] pc, input logic [31:0] reg1,
                              input logic [31:0] src2, input logic [31:0] expect_val);
    vec_t v;
    v.name = name; v.opc = opc; v.sel_pc = sel_pc; v.pc = pc;
    v.reg1 = reg1; v.src2 = src2; v.expect_val = expect_val;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Drive one cycle: check the combinational result, queue the registered expectation,
  // then check the registered output just after the following posedge.
  task automatic applyStimulus(input string name, input logic [3:0] opc, input logic sel_pc,
                               input logic [31:0] pc, input logic [31:0] reg1,
                               input logic [31:0] src2, input logic rst,
                               input logic [31:0] expect_comb);
    @(negedge clk);
    bus.exe_alu_opc_r = opc;
    bus.exe_sel_pc_r  = sel_pc;
    bus.exe_pc_r      = pc;
    bus.exe_reg1_r    = reg1;
    bus.exe_src2_r    = src2;
    reset             = rst;
    #1;
    checkOutput({name, "_comb"}, bus.alu_result, expect_comb);
    exp_q.push_back(rst ? 32'd0 : expect_comb);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({name, "_queue"}, 32'd1, 32'd0);
    end else begin
      checkOutput({name, "_reg"}, bus.alu_result_r, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [3:0]  ops [10];
    logic [3:0]  bad_ops [6];
    logic [31:0] a, b, pc, r1;
    logic [3:0]  opc;
    logic        sel;

    ops     = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hD};
    bad_ops = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.exe_alu_opc_r = 4'h0;
    bus.exe_sel_pc_r  = 1'b0;
    bus.exe_pc_r      = '0;
    bus.exe_reg1_r    = '0;
    bus.exe_src2_r    = '0;

    vecs.push_back(mk("and",       4'h7, 1'b0, 32'hDEAD_BEEF, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234));
    vecs.push_back(mk("or",        4'h6, 1'b0, 32'hDEAD_BEEF, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF));
    vecs.push_back(mk("xor",       4'h4, 1'b0, 32'hDEAD_BEEF, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB));
    vecs.push_back(mk("add_pc",    4'h0, 1'b1, 32'hFFFF_FFFC, 32'h0000_1234, 32'h0000_0008, 32'h0000_0004));
    vecs.push_back(mk("sub_pc",    4'h8, 1'b1, 32'hFFFF_FFFC, 32'h0000_1234, 32'h0000_0008, 32'hFFFF_FFF4));
    vecs.push_back(mk("slt_neg",   4'h2, 1'b0, 32'h0,         32'h8000_0000, 32'h0000_0001, 32'h0000_0001));
    vecs.push_back(mk("sltu_big",  4'h3, 1'b0, 32'h0,         32'h8000_0000, 32'h0000_0001, 32'h0000_0000));
    vecs.push_back(mk("slt_eq",    4'h2, 1'b0, 32'h0,         32'h0000_0005, 32'h0000_0005, 32'h0000_0000));
    vecs.push_back(mk("sltu_eq",   4'h3, 1'b0, 32'h0,         32'h0000_0005, 32'h0000_0005, 32'h0000_0000));
    vecs.push_back(mk("slt_m1",    4'h2, 1'b0, 32'h0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001));
    vecs.push_back(mk("sltu_m1",   4'h3, 1'b0, 32'h0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000));
    vecs.push_back(mk("sll_4",     4'h1, 1'b0, 32'h0,         32'h8000_0001, 32'hFFFF_FFE4, 32'h0000_0010));
    vecs.push_back(mk("srl_4",     4'h5, 1'b0, 32'h0,         32'h8000_0001, 32'hFFFF_FFE4, 32'h0800_0000));
    vecs.push_back(mk("sra_4",     4'hD, 1'b0, 32'h0,         32'h8000_0001, 32'hFFFF_FFE4, 32'hF800_0000));
    vecs.push_back(mk("sll_0",     4'h1, 1'b0, 32'h0,         32'h8000_0001, 32'h0000_0020, 32'h8000_0001));
    vecs.push_back(mk("srl_0",     4'h5, 1'b0, 32'h0,         32'h8000_0001, 32'h0000_0020, 32'h8000_0001));
    vecs.push_back(mk("sra_0",     4'hD, 1'b0, 32'h0,         32'h8000_0001, 32'h0000_0020, 32'h8000_0001));
    vecs.push_back(mk("sra_31",    4'hD, 1'b0, 32'h0,         32'h8000_0001, 32'h0000_001F, 32'hFFFF_FFFF));
    vecs.push_back(mk("srl_31",    4'h5, 1'b0, 32'h0,         32'h8000_0001, 32'h0000_001F, 32'h0000_0001));
    vecs.push_back(mk("sll_31",    4'h1, 1'b0, 32'h0,         32'h8000_0001, 32'h0000_001F, 32'h8000_0000));

    // Two reset cycles: combinational path live, register held at zero.
    applyStimulus("rst0", 4'h0, 1'b0, 32'h0, 32'h0000_0010, 32'h0000_0020, 1'b1, 32'h0000_0030);
    applyStimulus("rst1", 4'h6, 1'b0, 32'h0, 32'h0000_0F00, 32'h0000_00F0, 1'b1, 32'h0000_0FF0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].opc, vecs[i].sel_pc, vecs[i].pc,
                    vecs[i].reg1, vecs[i].src2, 1'b0, vecs[i].expect_val);
    end

    foreach (bad_ops[i]) begin
      applyStimulus("illegal", bad_ops[i], 1'(($urandom & 1)), $urandom, $urandom, $urandom,
                    1'b0, 32'd0);
    end

    // Mid-stream reset clears the register on the next edge, then it resumes tracking.
    applyStimulus("pre_rst", 4'h0, 1'b0, 32'h0, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003);
    applyStimulus("mid_rst", 4'h4, 1'b0, 32'h0, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b1, 32'h5555_5555);
    applyStimulus("post_rst", 4'h8, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF);

    for (int n = 0; n < 10000; n++) begin
      opc = ops[$urandom_range(9)];
      sel = 1'($urandom & 1);
      pc  = $urandom;
      r1  = $urandom;
      b   = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
      a   = sel ? pc : r1;
      applyStimulus("random", opc, sel, pc, r1, b, 1'b0, model(opc, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
